// File: rtl/adc_sample_source_if.sv
// Sample interface between the capture cache (master) and the ADC responder (slave).
interface adc_sample_source_if #(
  parameter int unsigned DATA_W = 8
);
  logic              req;
  logic [DATA_W-1:0] adc_data;
  logic              rdy;
  logic              busy;
  logic              overrun;
  logic [15:0]       sample_cnt;

  modport master (output req, input adc_data, rdy, busy, overrun, sample_cnt);
  modport slave  (input req, output adc_data, rdy, busy, overrun, sample_cnt);
endinterface

// File: rtl/adc_sample_source.sv
// Deterministic ADC responder: answers each request with a ramp sample, or with a
// trigger-pulse level at a fixed sample index, after a fixed conversion latency.
module adc_sample_source #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned CONV_CYCLES = 3,
  parameter int unsigned BASE_STEP   = 1,
  parameter int unsigned BASE_MAX    = 127,
  parameter int unsigned TRIG_INDEX  = 40,
  parameter int unsigned TRIG_WIDTH  = 4,
  parameter int unsigned TRIG_LEVEL  = 240
) (
  input  logic                clk,
  input  logic                reset,
  adc_sample_source_if.slave  if_adc
);
  localparam int unsigned CONV_W = 8;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_HOLD} state_t;

  state_t              r_state,    w_state;
  logic                r_req_q,    w_req_q;
  logic [CONV_W-1:0]   r_conv_cnt, w_conv_cnt;
  logic [DATA_W-1:0]   r_data,     w_data;
  logic                r_rdy,      w_rdy;
  logic                r_busy,     w_busy;
  logic                r_ovr,      w_ovr;
  logic [CNT_W-1:0]    r_cnt,      w_cnt;
  logic [DATA_W-1:0]   r_base,     w_base;

  logic                w_req_rise;
  logic [DATA_W:0]     w_sum;
  logic                w_pulse;
  logic [DATA_W-1:0]   w_sample;

  // Sample generator: baseline ramp with a pulse window keyed on the completed count
  assign w_req_rise = if_adc.req & ~r_req_q;
  assign w_sum      = {1'b0, r_base} + (DATA_W+1)'(BASE_STEP);
  assign w_pulse    = (32'(r_cnt) >= TRIG_INDEX) && (32'(r_cnt) < TRIG_INDEX + TRIG_WIDTH);
  assign w_sample   = w_pulse ? DATA_W'(TRIG_LEVEL) : r_base;

  // Next-state and registered-output logic
  always_comb begin
    w_state    = r_state;
    w_req_q    = if_adc.req;
    w_conv_cnt = r_conv_cnt;
    w_data     = r_data;
    w_rdy      = r_rdy;
    w_busy     = r_busy;
    w_ovr      = r_ovr;
    w_cnt      = r_cnt;
    w_base     = r_base;
    unique case (r_state)
      S_IDLE, S_HOLD: begin
        if (w_req_rise) begin
          w_state    = S_CONV;
          w_conv_cnt = CONV_W'(CONV_CYCLES - 1);
          w_rdy      = 1'b0;
          w_busy     = 1'b1;
        end
      end
      S_CONV: begin
        // Requests during a conversion are dropped but remembered as an overrun
        if (w_req_rise) w_ovr = 1'b1;
        if (r_conv_cnt != '0) begin
          w_conv_cnt = r_conv_cnt - CONV_W'(1);
        end else begin
          w_state = S_HOLD;
          w_data  = w_sample;
          w_rdy   = 1'b1;
          w_busy  = 1'b0;
          w_cnt   = r_cnt + CNT_W'(1);
          w_base  = (w_sum > (DATA_W+1)'(BASE_MAX)) ? '0 : w_sum[DATA_W-1:0];
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_req_q    <= 1'b0;
      r_conv_cnt <= '0;
      r_data     <= '0;
      r_rdy      <= 1'b0;
      r_busy     <= 1'b0;
      r_ovr      <= 1'b0;
      r_cnt      <= '0;
      r_base     <= '0;
    end else begin
      r_state    <= w_state;
      r_req_q    <= w_req_q;
      r_conv_cnt <= w_conv_cnt;
      r_data     <= w_data;
      r_rdy      <= w_rdy;
      r_busy     <= w_busy;
      r_ovr      <= w_ovr;
      r_cnt      <= w_cnt;
      r_base     <= w_base;
    end
  end

  assign if_adc.adc_data   = r_data;
  assign if_adc.rdy        = r_rdy;
  assign if_adc.busy       = r_busy;
  assign if_adc.overrun    = r_ovr;
  assign if_adc.sample_cnt = r_cnt;
endmodule

// File: tb/tb_adc_sample_source.sv
// Bench for adc_sample_source: three instances (default, 1-cycle conversion, step-50 ramp)
// share one stimulus stream and are checked every cycle against a timing/count model.
module tb_adc_sample_source;
  logic clk;
  logic reset;
  logic req;

  int n_checks = 0;
  int n_err    = 0;

  adc_sample_source_if #(.DATA_W(8)) if0 ();
  adc_sample_source_if #(.DATA_W(8)) if1 ();
  adc_sample_source_if #(.DATA_W(8)) if2 ();

  assign if0.req = req;
  assign if1.req = req;
  assign if2.req = req;

  adc_sample_source u_dut0 (.clk(clk), .reset(reset), .if_adc(if0));
  adc_sample_source #(.CONV_CYCLES(1)) u_dut1 (.clk(clk), .reset(reset), .if_adc(if1));
  adc_sample_source #(.BASE_STEP(50))  u_dut2 (.clk(clk), .reset(reset), .if_adc(if2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  // Expected k-th sample (k = completed conversions before this one)
  function automatic int exp_sample(input int k, input int step);
    int b = 0;
    for (int i = 0; i < k; i++) b = (b + step > 127) ? 0 : b + step;
    if ((k % 65536) >= 40 && (k % 65536) < 44) return 240;
    return b;
  endfunction

  // Model: each instance tracks the edge at which its current conversion finishes
  int   m_conv[3] = '{3, 1, 3};
  int   m_step[3] = '{1, 1, 50};
  int   m_done[3];
  int   m_cnt[3];
  int   m_data[3];
  logic m_rdy[3], m_busy[3], m_ovr[3], m_prev[3];
  int   e;

  initial begin
    e = 0;
    for (int i = 0; i < 3; i++) begin
      m_done[i] = -1; m_cnt[i] = 0; m_data[i] = 0;
      m_rdy[i] = 0; m_busy[i] = 0; m_ovr[i] = 0; m_prev[i] = 0;
    end
    forever begin
      logic        in_conv, rise;
      logic [7:0]  o_data[3];
      logic        o_rdy[3], o_busy[3], o_ovr[3];
      logic [15:0] o_cnt[3];
      @(posedge clk);
      #1;
      e++;
      for (int i = 0; i < 3; i++) begin
        if (reset) begin
          m_done[i] = -1; m_cnt[i] = 0; m_data[i] = 0;
          m_rdy[i] = 0; m_busy[i] = 0; m_ovr[i] = 0; m_prev[i] = 0;
        end else begin
          rise      = req && !m_prev[i];
          m_prev[i] = req;
          in_conv   = (m_done[i] >= e);
          if (rise) begin
            if (in_conv) m_ovr[i] = 1;
            else begin
              m_busy[i] = 1; m_rdy[i] = 0; m_done[i] = e + m_conv[i];
            end
          end
          if (in_conv && m_done[i] == e) begin
            m_rdy[i]  = 1; m_busy[i] = 0;
            m_data[i] = exp_sample(m_cnt[i], m_step[i]);
            m_cnt[i]  = (m_cnt[i] + 1) % 65536;
          end
        end
      end
      o_data[0] = if0.adc_data; o_rdy[0] = if0.rdy; o_busy[0] = if0.busy;
      o_ovr[0]  = if0.overrun;  o_cnt[0] = if0.sample_cnt;
      o_data[1] = if1.adc_data; o_rdy[1] = if1.rdy; o_busy[1] = if1.busy;
      o_ovr[1]  = if1.overrun;  o_cnt[1] = if1.sample_cnt;
      o_data[2] = if2.adc_data; o_rdy[2] = if2.rdy; o_busy[2] = if2.busy;
      o_ovr[2]  = if2.overrun;  o_cnt[2] = if2.sample_cnt;
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("e%0d.u%0d.adc_data", e, i), 32'(o_data[i]), 32'(m_data[i]));
        chk($sformatf("e%0d.u%0d.rdy", e, i), 32'(o_rdy[i]), 32'(m_rdy[i]));
        chk($sformatf("e%0d.u%0d.busy", e, i), 32'(o_busy[i]), 32'(m_busy[i]));
        chk($sformatf("e%0d.u%0d.overrun", e, i), 32'(o_ovr[i]), 32'(m_ovr[i]));
        chk($sformatf("e%0d.u%0d.sample_cnt", e, i), 32'(o_cnt[i]), 32'(m_cnt[i]));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // One handshake on the 3-cycle instances; returns the completed samples
  task automatic hs(output logic [7:0] d0, output logic [7:0] d2);
    req = 1'b1; tick;
    req = 1'b0; tick; tick; tick;
    chk("hs.rdy", 32'(if0.rdy), 32'd1);
    d0 = if0.adc_data;
    d2 = if2.adc_data;
  endtask

  logic [7:0] d0[46];
  logic [7:0] d2[46];
  logic [7:0] t0, t2;

  initial begin
    reset = 1'b1;
    req   = 1'b0;
    tick; req = 1'b1; tick; req = 1'b0; tick;
    chk("rst.rdy", 32'(if0.rdy), 32'd0);
    chk("rst.busy", 32'(if0.busy), 32'd0);
    chk("rst.adc_data", 32'(if0.adc_data), 32'd0);
    chk("rst.sample_cnt", 32'(if0.sample_cnt), 32'd0);
    reset = 1'b0;
    tick;

    // latency on the first handshake
    req = 1'b1; tick;
    chk("lat.u0.busy_n", 32'(if0.busy), 32'd1);
    chk("lat.u1.busy_n", 32'(if1.busy), 32'd1);
    req = 1'b0; tick;
    chk("lat.u1.rdy_n1", 32'(if1.rdy), 32'd1);
    chk("lat.u1.cnt_n1", 32'(if1.sample_cnt), 32'd1);
    chk("lat.u0.rdy_n1", 32'(if0.rdy), 32'd0);
    tick;
    chk("lat.u0.busy_n2", 32'(if0.busy), 32'd1);
    tick;
    chk("lat.u0.rdy_n3", 32'(if0.rdy), 32'd1);
    chk("lat.u0.busy_n3", 32'(if0.busy), 32'd0);
    chk("lat.u0.data", 32'(if0.adc_data), 32'd0);
    chk("lat.u0.cnt", 32'(if0.sample_cnt), 32'd1);
    d0[0] = if0.adc_data;
    d2[0] = if2.adc_data;

    for (int k = 1; k < 46; k++) hs(d0[k], d2[k]);
    chk("ramp.s1", 32'(d2[1]), 32'd50);
    chk("ramp.s2", 32'(d2[2]), 32'd100);
    chk("ramp.s3", 32'(d2[3]), 32'd0);
    chk("trig.s39", 32'(d0[39]), 32'd39);
    chk("trig.s40", 32'(d0[40]), 32'd240);
    chk("trig.s43", 32'(d0[43]), 32'd240);
    chk("trig.s44", 32'(d0[44]), 32'd44);
    chk("trig.s45", 32'(d0[45]), 32'd45);
    chk("trig.u1.last", 32'(if1.adc_data), 32'd45);

    // second rise one clock after acceptance
    req = 1'b1; tick;
    req = 1'b0; tick;
    req = 1'b1; tick;
    chk("ovr.flag", 32'(if0.overrun), 32'd1);
    chk("ovr.rdy_early", 32'(if0.rdy), 32'd0);
    req = 1'b0; tick;
    chk("ovr.rdy", 32'(if0.rdy), 32'd1);
    chk("ovr.cnt", 32'(if0.sample_cnt), 32'd47);
    chk("ovr.data", 32'(if0.adc_data), 32'd46);
    chk("ovr.u1.flag", 32'(if1.overrun), 32'd0);
    tick;
    hs(t0, t2);
    chk("ovr.next.data", 32'(t0), 32'd47);
    chk("ovr.next.cnt", 32'(if0.sample_cnt), 32'd48);
    chk("ovr.sticky", 32'(if0.overrun), 32'd1);

    // reset one edge into a conversion
    req = 1'b1; tick;
    req = 1'b0; reset = 1'b1; tick;
    reset = 1'b0; tick; tick; tick; tick;
    chk("rstmid.rdy", 32'(if0.rdy), 32'd0);
    chk("rstmid.busy", 32'(if0.busy), 32'd0);
    chk("rstmid.cnt", 32'(if0.sample_cnt), 32'd0);
    chk("rstmid.ovr", 32'(if0.overrun), 32'd0);
    hs(t0, t2);
    chk("rstmid.data", 32'(t0), 32'd0);
    chk("rstmid.cnt1", 32'(if0.sample_cnt), 32'd1);
    tick; tick;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/adc_sample_source.md
Name: adc_sample_source

Overview:
Behavioural/synthesizable ADC responder at the far end of the TriggerSurroundCache sample interface. It answers each `req` from the cache with one 8-bit conversion result on `adc_data` and a `rdy` strobe, after a programmable conversion latency. Samples come from a deterministic generator: a baseline ramp plus an injected trigger pulse at a known sample index. The cache's trigger detect, pre/post capture and timestamp can therefore be checked against exact values.

Parameters:
- DATA_W, 8, sample width; must match cache `adc_data`.
- CONV_CYCLES, 3, clocks from accepted request to `rdy`; legal range 1..255.
- BASE_STEP, 1, baseline increment per sample.
- BASE_MAX, 127, baseline wraps to 0 when the next value would exceed this.
- TRIG_INDEX, 40, sample index of the first trigger-pulse sample.
- TRIG_WIDTH, 4, number of consecutive trigger-pulse samples; 0 disables the pulse.
- TRIG_LEVEL, 240, sample value during the pulse.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  conversion request from cache; rising edge is detected internally.
- adc_data  out  DATA_W  last conversion result, registered.
- rdy  out  1  result valid; held high until the next accepted request.
- busy  out  1  high while a conversion is in progress.
- overrun  out  1  sticky; set when a request arrives during a conversion.
- sample_cnt  out  16  number of completed conversions; wraps at 2^16.

Behaviour:
- Clocking and reset:
  - All state changes on the rising edge of `clk`.
  - `reset` sampled high forces: state=IDLE, `adc_data`=0, `rdy`=0, `busy`=0, `overrun`=0, `sample_cnt`=0, baseline=0, internal req_q=0, conv_cnt=0.
  - Reset mid-conversion abandons the conversion; no `rdy` follows.
- Request detect:
  - req_q is registered `req`. An accepted request is `req`=1 and req_q=0 at a clock edge.
  - A pulse not high at any rising edge is missed by design; the cache must hold `req` for at least one edge.
  - A held-high `req` counts as exactly one request.
- FSM states: IDLE, CONV, HOLD.
  - IDLE: on request -> CONV, conv_cnt<=CONV_CYCLES-1, `busy`<=1.
  - CONV:
    - If conv_cnt!=0: conv_cnt decrements.
    - If conv_cnt==0: `adc_data`<=next sample, `rdy`<=1, `busy`<=0, `sample_cnt`<=`sample_cnt`+1, baseline advances -> HOLD.
  - HOLD: `rdy` and `adc_data` stable. On request: `rdy`<=0, `busy`<=1, conv_cnt<=CONV_CYCLES-1 -> CONV.
- Latency: request accepted at edge N gives `rdy`=1 after edge N+CONV_CYCLES. CONV_CYCLES=1 gives `rdy` after edge N+1.
- Request during CONV: ignored (no restart, no queueing); `overrun`<=1 and stays set until reset. Conversion completes on its original schedule.
- Next-sample value, where k = current `sample_cnt` before increment:
  - TRIG_INDEX <= k < TRIG_INDEX+TRIG_WIDTH: value = TRIG_LEVEL.
  - Otherwise: value = baseline.
  - The baseline advances every conversion, including pulse samples.
- Baseline update: computed in DATA_W+1 bits; sum = baseline+BASE_STEP. If sum > BASE_MAX, baseline<=0; else baseline<=sum[DATA_W-1:0].
- Pulse index compare uses 16-bit `sample_cnt`; after wrap the pulse recurs every 65536 samples.
- `adc_data` changes only on the CONV->HOLD edge; never glitches during CONV.

Test Plan:
1. Reset: assert `reset` 2 clocks with `req` toggling -> all outputs 0; no `rdy`.
2. Latency: defaults, single `req` high 1 clock at edge N -> `busy` high edges N..N+2, `rdy`=1 after N+3, `adc_data`=0, `sample_cnt`=1. Repeat with CONV_CYCLES=1 -> `rdy` after N+1.
3. Ramp wrap: BASE_STEP=50, BASE_MAX=127, 4 handshakes -> `adc_data` 0, 50, 100, 0.
4. Trigger pulse: defaults, 46 handshakes -> samples 0..39 equal k, samples 40..43 equal 240, samples 44..45 equal 44 and 45.
5. Overrun: second `req` rise 1 clock after first accepted -> `overrun`=1, single `rdy` at original time, `sample_cnt`=1. A following `req` in HOLD is accepted normally; `overrun` remains 1.
6. Reset mid-conversion: `reset` at edge N+1 of a CONV_CYCLES=3 conversion -> no `rdy`, `busy`=0. The next request yields `adc_data`=0 after 3 clocks.
